fifo8_buffer: RTL and testbench

//   8-entry circular FIFO with valid/ready handshakes on both sides.

---
 rtl/fifo8_buffer.sv | 85 ++++++++
 tb/tb_fifo8_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo8_buffer.sv
// 8-entry circular FIFO with valid/ready handshakes on both sides.
// All storage words and the read pointer are exposed so a downstream mux8 forms the head word.
module fifo8_buffer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [N-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [N-1:0] entry_0,
    output logic [N-1:0] entry_1,
    output logic [N-1:0] entry_2,
    output logic [N-1:0] entry_3,
    output logic [N-1:0] entry_4,
    output logic [N-1:0] entry_5,
    output logic [N-1:0] entry_6,
    output logic [N-1:0] entry_7,
    output logic [2:0]   rd_ptr,
    output logic [3:0]   count,
    output logic         full,
    output logic         empty,
    output logic         overflow
);

    logic [N-1:0] mem [8];
    logic [2:0]   wr_ptr;
    logic         push;
    logic         pop;

    // Flags depend on count only, so the handshakes never loop through wr_valid/rd_ready.
    assign full     = (count == 4'd8);
    assign empty    = (count == 4'd0);
    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    assign entry_0 = mem[0];
    assign entry_1 = mem[1];
    assign entry_2 = mem[2];
    assign entry_3 = mem[3];
    assign entry_4 = mem[4];
    assign entry_5 = mem[5];
    assign entry_6 = mem[6];
    assign entry_7 = mem[7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (wr_valid && full) begin
                overflow <= 1'b1;
            end
            if (clear) begin
                wr_ptr <= 3'd0;
                rd_ptr <= 3'd0;
                count  <= 4'd0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= wr_data;
                    wr_ptr      <= wr_ptr + 3'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 3'd1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 4'd1;
                    2'b01:   count <= count - 4'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo8_buffer.sv
// Self-checking bench for fifo8_buffer: scoreboard queue of pushed words, popped words
// compared against the mux8-selected head, plus a small reference model of pointers/count.
module tb_fifo8_buffer;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         wr_valid;
    logic         wr_ready;
    logic [N-1:0] wr_data;
    logic         rd_valid;
    logic         rd_ready;
    logic [N-1:0] entry_0, entry_1, entry_2, entry_3;
    logic [N-1:0] entry_4, entry_5, entry_6, entry_7;
    logic [2:0]   rd_ptr;
    logic [3:0]   count;
    logic         full;
    logic         empty;
    logic         overflow;

    fifo8_buffer #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .entry_0  (entry_0),
        .entry_1  (entry_1),
        .entry_2  (entry_2),
        .entry_3  (entry_3),
        .entry_4  (entry_4),
        .entry_5  (entry_5),
        .entry_6  (entry_6),
        .entry_7  (entry_7),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] dut_entries [8];
    logic [N-1:0] head;

    always_comb begin
        dut_entries[0] = entry_0;
        dut_entries[1] = entry_1;
        dut_entries[2] = entry_2;
        dut_entries[3] = entry_3;
        dut_entries[4] = entry_4;
        dut_entries[5] = entry_5;
        dut_entries[6] = entry_6;
        dut_entries[7] = entry_7;
    end

    // Stand-in for the downstream mux8.
    always_comb begin
        head = '0;
        case (rd_ptr)
            3'd0: head = entry_0;
            3'd1: head = entry_1;
            3'd2: head = entry_2;
            3'd3: head = entry_3;
            3'd4: head = entry_4;
            3'd5: head = entry_5;
            3'd6: head = entry_6;
            3'd7: head = entry_7;
            default: head = '0;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] sb [$];
    logic [N-1:0] m_mem [8];
    int           m_count;
    int           m_rd;
    int           m_wr;
    logic         m_ovf;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_count = 0;
        m_rd    = 0;
        m_wr    = 0;
        m_ovf   = 1'b0;
        sb.delete();
    endtask

    task automatic check_entries(input string tag);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("%s_entry%0d", tag, i), 64'(dut_entries[i]), 64'(m_mem[i]));
        end
    endtask

    // One clock cycle: drive at negedge, check handshake/head, then state after posedge.
    task automatic step(input logic wv, input logic [N-1:0] wd, input logic rr, input logic clr);
        logic do_push;
        logic do_pop;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        clear    = clr;
        #1;
        check_val("wr_ready", 64'(wr_ready), 64'(m_count != 8));
        check_val("rd_valid", 64'(rd_valid), 64'(m_count != 0));
        do_push = wv && (m_count < 8);
        do_pop  = rr && (m_count > 0);
        if (!clr && do_pop) begin
            check_val("head", 64'(head), 64'(sb.pop_front()));
        end
        if (wv && m_count == 8) m_ovf = 1'b1;
        if (clr) begin
            m_count = 0;
            m_rd    = 0;
            m_wr    = 0;
            sb.delete();
        end else begin
            if (do_push) begin
                sb.push_back(wd);
                m_mem[m_wr] = wd;
                m_wr = (m_wr + 1) % 8;
            end
            if (do_pop) m_rd = (m_rd + 1) % 8;
            if (do_push && !do_pop) m_count++;
            if (do_pop && !do_push) m_count--;
        end
        @(posedge clk);
        #1;
        check_val("count", 64'(count), 64'(m_count));
        check_val("rd_ptr", 64'(rd_ptr), 64'(m_rd));
        check_val("overflow", 64'(overflow), 64'(m_ovf));
        @(negedge clk);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        int start_ptr;
        rst      = 1'b0;
        clear    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        model_reset();

        #12;
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_full", 64'(full), 64'd0);
        check_val("rst_wr_ready", 64'(wr_ready), 64'd1);
        check_val("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_val("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill and drain
        for (int i = 1; i <= 8; i++) step(1'b1, N'(i * 'h11), 1'b0, 1'b0);
        check_val("t2_full", 64'(full), 64'd1);
        check_val("t2_wr_ready", 64'(wr_ready), 64'd0);
        check_val("t2_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_val("t2_empty", 64'(empty), 64'd1);

        // Wrap through slot 7 -> 0
        for (int i = 0; i < 6; i++) step(1'b1, N'(32'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, N'(32'hA0 + i), 1'b0, 1'b0);
        check_val("t3_slot6", 64'(entry_6), 64'h0A0);
        check_val("t3_slot7", 64'(entry_7), 64'h0A1);
        check_val("t3_slot0", 64'(entry_0), 64'h0A2);
        check_val("t3_slot1", 64'(entry_1), 64'h0A3);
        check_val("t3_rd_ptr", 64'(rd_ptr), 64'd6);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++) step(1'b1, N'(32'h300 + i), 1'b0, 1'b0);
        start_ptr = int'(rd_ptr);
        for (int i = 0; i < 4; i++) step(1'b1, N'(32'h400 + i), 1'b1, 1'b0);
        check_val("t4_count", 64'(count), 64'd3);
        check_val("t4_rd_ptr", 64'(rd_ptr), 64'((start_ptr + 4) % 8));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_val("t4_empty", 64'(empty), 64'd1);

        // Write attempted while full
        for (int i = 0; i < 8; i++) step(1'b1, N'(32'h500 + i), 1'b0, 1'b0);
        step(1'b1, N'(32'hDEAD), 1'b0, 1'b0);
        check_val("t5_overflow", 64'(overflow), 64'd1);
        check_val("t5_count", 64'(count), 64'd8);
        check_entries("t5");
        step(1'b0, '0, 1'b0, 1'b0);
        check_val("t5_sticky", 64'(overflow), 64'd1);

        // Clear with push+pop in the same cycle
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_val("t6_pre_count", 64'(count), 64'd4);
        step(1'b1, N'(32'h5555), 1'b1, 1'b1);
        check_val("t6_count", 64'(count), 64'd0);
        check_val("t6_rd_ptr", 64'(rd_ptr), 64'd0);
        check_val("t6_overflow", 64'(overflow), 64'd1);
        check_entries("t6");
        step(1'b1, N'(32'h77), 1'b0, 1'b0);
        check_val("t6_slot0", 64'(entry_0), 64'h77);

        // Asynchronous reset mid-run with count 5
        for (int i = 0; i < 4; i++) step(1'b1, N'(32'h600 + i), 1'b0, 1'b0);
        check_val("t1_pre_count", 64'(count), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_val("t1_count", 64'(count), 64'd0);
        check_val("t1_rd_ptr", 64'(rd_ptr), 64'd0);
        check_val("t1_empty", 64'(empty), 64'd1);
        check_val("t1_overflow", 64'(overflow), 64'd0);
        check_entries("t1");
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, N'(32'hBEEF), 1'b0, 1'b0);
        check_val("t1_after_slot0", 64'(entry_0), 64'hBEEF);
        step(1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
